vga_timing_ctrl: RTL



---
 rtl/vga_timing_ctrl_pkg.sv | 29 ++
 rtl/vga_timing_ctrl_sync_pipe.sv | 27 ++
 rtl/vga_timing_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared timing defaults and pixel type for the VGA timing controller.
package vga_timing_ctrl_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_FB_W     = 320;
  localparam int unsigned DEF_FB_H     = 240;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned PIX_W      = 16;
  localparam int unsigned PIPE_DEPTH = 3;

  // RGB565 pixel as read from the frame buffer
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_timing_ctrl_sync_pipe.sv
// N-stage delay line with async reset to a configurable idle value.
module sync_pipe #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [N];

  // Shift register; reset forces every stage to the idle value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[N-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing with 2x upscaled frame-buffer fetch; all outputs 3 cycles behind the counters.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned FB_W     = DEF_FB_W,
  parameter int unsigned FB_H     = DEF_FB_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rd_data,
  output logic [16:0] rd_addr,
  output logic        rd_en,
  output logic [15:0] Dout,
  output logic        Nblank,
  output logic        Hsync,
  output logic        Vsync,
  output logic        frame_start
);

  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam int unsigned LB_MAX = (FB_H - 1) * FB_W;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              act_d2;
  rgb565_t           pix_q;

  logic h_last_c, v_last_c, active_c, hsync_c, vsync_c, fstart_c;

  // Raster decode of the current counter state
  always_comb begin
    h_last_c = (h_cnt == HW'(H_TOT - 1));
    v_last_c = (v_cnt == VW'(V_TOT - 1));
    active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hsync_c  = !((h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END)));
    vsync_c  = !((v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END)));
    fstart_c = (h_cnt == '0) && (v_cnt == '0);
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last_c) begin
      h_cnt <= '0;
      v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Source-row base address: steps one FB row after every second active line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
    end else if (h_last_c) begin
      if (v_last_c) begin
        line_base <= '0;
      end else if (v_cnt[0] && (v_cnt < VW'(V_ACTIVE)) && (line_base != ADDR_W'(LB_MAX))) begin
        line_base <= line_base + ADDR_W'(FB_W);
      end
    end
  end

  // Fetch stage: address is base plus half the column, held at 0 in blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en   <= active_c;
      rd_addr <= active_c ? line_base + ADDR_W'(h_cnt >> 1) : '0;
    end
  end

  // Track the RAM latency, then capture the returned pixel or black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d2 <= 1'b0;
      pix_q  <= '0;
    end else begin
      act_d2 <= rd_en;
      pix_q  <= act_d2 ? rgb565_t'(rd_data) : '0;
    end
  end

  assign Dout = pix_q;

  sync_pipe #(
    .N       (PIPE_DEPTH),
    .W       (4),
    .RST_VAL (4'b1100)
  ) u_sync_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hsync_c, vsync_c, active_c, fstart_c}),
    .q     ({Hsync, Vsync, Nblank, frame_start})
  );

endmodule
